// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INC    = 32'd4;

endpackage

// File: rtl/fetch_target_sel.sv
// Redirect target mux: register jump or PC-relative target, word aligned.
module fetch_target_sel (
  input  logic        i_jtype,
  input  logic [31:0] i_alu_out,
  input  logic [31:0] i_pc_plus_imm,
  output logic [31:0] o_target
);

  logic [31:0] w_raw;

  always_comb begin
    w_raw    = i_jtype ? {i_alu_out[31:1], 1'b0} : i_pc_plus_imm;
    o_target = {w_raw[31:2], 2'b00};
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, drives a variable-latency imem and the IF/ID outputs.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallF,
  input  logic             BranchM,
  input  logic             JtypeM,
  input  logic [31:0]      PCPlusImmM,
  input  logic [31:0]      ALUOutM,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      PCD,
  output logic [31:0]      InstrD,
  output logic             ValidD,
  output logic             FetchBusy,
  output logic [CNT_W-1:0] WaitCount,
  output logic [1:0]       o_dbg_state
);

  // Handshake: imem_req stays high with imem_addr stable until a cycle with
  // imem_ready=1 completes it; imem_ready is ignored whenever imem_req=0.

  fetch_state_e     r_state, w_state_nxt;
  logic [31:0]      r_pc, w_pc_nxt;
  logic [31:0]      r_addr, w_addr_nxt;
  logic [31:0]      r_pcd, w_pcd_nxt;
  logic [31:0]      r_instr, w_instr_nxt;
  logic             r_valid, w_valid_nxt;
  logic [CNT_W-1:0] r_wait;
  logic [31:0]      w_target;
  logic [31:0]      w_addr_inc;
  logic             w_req;
  logic             w_busy;

  fetch_target_sel u_target_sel (
    .i_jtype      (JtypeM),
    .i_alu_out    (ALUOutM),
    .i_pc_plus_imm(PCPlusImmM),
    .o_target     (w_target)
  );

  assign w_addr_inc = r_addr + PC_INC;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_addr_nxt  = r_addr;
    w_pcd_nxt   = r_pcd;
    w_instr_nxt = r_instr;
    w_valid_nxt = r_valid;
    w_req       = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_addr_nxt  = r_pc;
        w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        w_req = 1'b1;
        if (BranchM) begin
          w_valid_nxt = 1'b0;
          w_pc_nxt    = w_target;
          if (imem_ready) begin
            w_addr_nxt = w_target;
          end else begin
            w_state_nxt = ST_DISCARD;
          end
        end else if (StallF) begin
          // Everything holds; a response arriving now is refetched later.
          w_state_nxt = ST_FETCH;
        end else if (imem_ready) begin
          w_pcd_nxt   = r_addr;
          w_instr_nxt = imem_rdata;
          w_valid_nxt = 1'b1;
          w_pc_nxt    = w_addr_inc;
          w_addr_nxt  = w_addr_inc;
        end else begin
          w_valid_nxt = 1'b0;
        end
      end
      ST_DISCARD: begin
        w_req       = 1'b1;
        w_valid_nxt = 1'b0;
        if (BranchM) begin
          w_pc_nxt = w_target;
        end
        if (imem_ready) begin
          w_addr_nxt  = BranchM ? w_target : r_pc;
          w_state_nxt = ST_FETCH;
        end
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
      r_pcd   <= 32'h0000_0000;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_addr  <= w_addr_nxt;
      r_pcd   <= w_pcd_nxt;
      r_instr <= w_instr_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign w_busy = w_req & ~imem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait <= '0;
    end else if (w_busy && (r_wait != {CNT_W{1'b1}})) begin
      r_wait <= r_wait + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign imem_req    = w_req;
  assign imem_addr   = r_addr;
  assign PCD         = r_pcd;
  assign InstrD      = r_instr;
  assign ValidD      = r_valid;
  assign FetchBusy   = w_busy;
  assign WaitCount   = r_wait;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a combinational instruction memory model.
module tb_fetch_sequencer;

  localparam int CNT_W = 16;

  logic             clk;
  logic             reset;
  logic             StallF;
  logic             BranchM;
  logic             JtypeM;
  logic [31:0]      PCPlusImmM;
  logic [31:0]      ALUOutM;
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_ready;
  logic [31:0]      imem_rdata;
  logic [31:0]      PCD;
  logic [31:0]      InstrD;
  logic             ValidD;
  logic             FetchBusy;
  logic [CNT_W-1:0] WaitCount;
  logic [1:0]       o_dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .StallF     (StallF),
    .BranchM    (BranchM),
    .JtypeM     (JtypeM),
    .PCPlusImmM (PCPlusImmM),
    .ALUOutM    (ALUOutM),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .PCD        (PCD),
    .InstrD     (InstrD),
    .ValidD     (ValidD),
    .FetchBusy  (FetchBusy),
    .WaitCount  (WaitCount),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // memory model: the word at an address is a known function of that address
  assign imem_rdata = instr_of(imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fetched(input string tag, input logic [31:0] pc);
    check({tag, "_pcd"}, PCD, pc);
    check({tag, "_instr"}, InstrD, instr_of(pc));
    check({tag, "_valid"}, {31'd0, ValidD}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; StallF = 1'b0; BranchM = 1'b0; JtypeM = 1'b0;
    PCPlusImmM = '0; ALUOutM = '0; imem_ready = 1'b0;
    tick(); tick();
    check("rst_pcd", PCD, 32'h0);
    check("rst_instr", InstrD, 32'h0000_0013);
    check("rst_valid", {31'd0, ValidD}, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_wait", {16'd0, WaitCount}, 32'd0);
    check("rst_state", {30'd0, o_dbg_state}, 32'd0);

    // zero-wait memory straight out of reset
    imem_ready = 1'b1;
    reset = 1'b0;
    #1;
    check("boot_req", {31'd0, imem_req}, 32'd0);
    tick();
    check("boot_state", {30'd0, o_dbg_state}, 32'd1);
    check("boot_addr", imem_addr, 32'h0);
    check("boot_valid", {31'd0, ValidD}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_fetched("seq", 32'(i * 4));
    end
    check("seq_busy", {31'd0, FetchBusy}, 32'd0);
    check("seq_wait", {16'd0, WaitCount}, 32'd0);

    // two wait states per instruction
    for (int i = 0; i < 10; i++) exp_q.push_back(32'h0C + 32'(i * 4));
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 3; k++) begin
        imem_ready = (k == 2);
        #1;
        check("ws_busy", {31'd0, FetchBusy}, (k == 2) ? 32'd0 : 32'd1);
        tick();
        if (k == 2) check_fetched("ws", exp_q.pop_front());
        else check("ws_bubble", {31'd0, ValidD}, 32'd0);
      end
    end
    check("ws_wait", {16'd0, WaitCount}, 32'd20);

    // redirect while 0x34 is outstanding; a second redirect in DISCARD wins
    imem_ready = 1'b0; BranchM = 1'b1; PCPlusImmM = 32'h100;
    tick();
    check("dis_state", {30'd0, o_dbg_state}, 32'd2);
    check("dis_addr0", imem_addr, 32'h34);
    check("dis_valid0", {31'd0, ValidD}, 32'd0);
    check("dis_pcd", PCD, 32'h30);
    PCPlusImmM = 32'h180;
    tick();
    check("dis_addr1", imem_addr, 32'h34);
    check("dis_valid1", {31'd0, ValidD}, 32'd0);
    BranchM = 1'b0; imem_ready = 1'b1;
    tick();
    check("dis_exit_state", {30'd0, o_dbg_state}, 32'd1);
    check("dis_new_addr", imem_addr, 32'h180);
    check("dis_valid2", {31'd0, ValidD}, 32'd0);
    tick();
    check_fetched("dis_first", 32'h180);
    check("dis_wait", {16'd0, WaitCount}, 32'd22);

    // register jump with a misaligned target, response ready the same cycle
    BranchM = 1'b1; JtypeM = 1'b1; ALUOutM = 32'h203;
    tick();
    check("jr_addr", imem_addr, 32'h200);
    check("jr_valid", {31'd0, ValidD}, 32'd0);
    check("jr_state", {30'd0, o_dbg_state}, 32'd1);
    BranchM = 1'b0; JtypeM = 1'b0;
    tick();
    check_fetched("jr_first", 32'h200);

    // stall with ready responses: nothing advances
    StallF = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_fetched("stall", 32'h200);
      check("stall_addr", imem_addr, 32'h204);
    end
    StallF = 1'b0;
    tick();
    check_fetched("stall_rel", 32'h204);

    // PC-relative target with low bits set, then wrap past 2^32
    BranchM = 1'b1; PCPlusImmM = 32'hFFFF_FFFE;
    tick();
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    BranchM = 1'b0;
    tick();
    check_fetched("wrap_top", 32'hFFFF_FFFC);
    check("wrap_addr1", imem_addr, 32'h0);
    tick();
    check_fetched("wrap_zero", 32'h0);

    // asynchronous reset while a stale response is pending
    imem_ready = 1'b0; BranchM = 1'b1; PCPlusImmM = 32'h300;
    tick();
    check("rd_state", {30'd0, o_dbg_state}, 32'd2);
    BranchM = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("rd_req", {31'd0, imem_req}, 32'd0);
    check("rd_pcd", PCD, 32'h0);
    check("rd_instr", InstrD, 32'h0000_0013);
    check("rd_valid", {31'd0, ValidD}, 32'd0);
    check("rd_wait", {16'd0, WaitCount}, 32'd0);
    check("rd_addr", imem_addr, 32'h0);
    imem_ready = 1'b1;
    tick();
    check("rd_hold_state", {30'd0, o_dbg_state}, 32'd0);
    reset = 1'b0;
    tick();
    check("rd_fetch_addr", imem_addr, 32'h0);
    check("rd_fetch_valid", {31'd0, ValidD}, 32'd0);
    tick();
    check_fetched("rd_first", 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
